sev_seg_scan_ctrl: RTL

- Time-multiplexes NUM_DIGITS BCD digits onto one shared seven-segment decoder and segment bus.
- Each scan slot drives the 4-bit `data` input of the existing decoder and selects one common digit line with an active-low enable.
- A guard interval with all digits off precedes every digit to stop ghosting.
- New display values arrive over a valid/ready handshake and take effect only at a frame boundary, so a frame never shows mixed old and new values.

---
 rtl/sev_seg_scan_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with guard blanking and frame-aligned loads.
// Optional leading-zero blanking: define SEV_SEG_LEADING_ZERO_BLANK_EN.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              data,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  logic [3:0]            data_q, data_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic                  frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] hide;
  logic                  accept;
  logic                  idx_wrap;

  function automatic logic [3:0] digit_of(input logic [DW-1:0] vec, input logic [IW-1:0] sel);
    digit_of = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel == IW'(k)) digit_of = vec[4*k +: 4];
    end
  endfunction

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // A digit is hidden when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    hide       = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (shadow_q[4*k +: 4] == 4'd0);
      hide[k]    = upper_zero;
    end
  end
`else
  always_comb begin
    hide = '0;
  end
`endif

  assign accept   = load_valid && !pend_full_q;
  assign idx_wrap = (idx_q == IDX_LAST);

  always_comb begin
    // NOTE: every _d starts from its hold value, so no branch can leave a variable unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_full_d  = pend_full_q;
    data_d       = data_q;
    digit_en_n_d = digit_en_n_q;
    frame_done_d = 1'b0;

    if (accept) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end

    if (!enable) begin
      state_d      = ST_BLANK;
      cnt_d        = '0;
      idx_d        = '0;
      digit_en_n_d = '1;
      if (pend_full_q) begin
        shadow_d    = pending_q;
        pend_full_d = 1'b0;
      end
      data_d = digit_of(shadow_d, '0);
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          data_d = digit_of(shadow_q, idx_q);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (idx_q == IW'(k) && !hide[k]) digit_en_n_d[k] = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d      = ST_BLANK;
            cnt_d        = '0;
            digit_en_n_d = '1;
            if (idx_wrap) begin
              // Frame boundary: the only point a pending value may replace the shadow.
              idx_d        = '0;
              frame_done_d = 1'b1;
              if (pend_full_q) begin
                shadow_d    = pending_q;
                pend_full_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + IW'(1);
            end
            data_d = digit_of(shadow_d, idx_d);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      data_q       <= 4'd0;
      digit_en_n_q <= '1;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values and updates together.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      data_q       <= data_d;
      digit_en_n_q <= digit_en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = !pend_full_q;
  assign data       = data_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_done = frame_done_q;

endmodule
